// File: rtl/bus_arbit.sv
// rtl/bus_arbit.sv - two-master bus arbiter with bounded hold under contention
//
// Purpose: grants the shared bus to one of two masters. When only one master
// requests, it gets the bus. When neither requests, the bus parks on master 0.
// When both request, the current owner keeps the bus for MAX_HOLD contended
// cycles, and then ownership passes to the other master.
//
// Parameters:
//   MAX_HOLD   consecutive contended cycles one master keeps the grant (2..256)
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   m0_req     master 0 bus request
//   m1_req     master 1 bus request
//   m0_wr      master 0 write enable
//   m0_addr    master 0 address [7:0]
//   m0_dout    master 0 write data [31:0]
//   m1_wr      master 1 write enable
//   m1_addr    master 1 address [7:0]
//   m1_dout    master 1 write data [31:0]
//   m0_grant   master 0 owns the bus (decoded from the state register)
//   m1_grant   master 1 owns the bus (decoded from the state register)
//   s_wr       write enable of the granted master
//   s_addr     address of the granted master [7:0]
//   s_din      write data of the granted master [31:0]

module bus_arbit #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic [7:0]  m0_addr,
  input  logic [31:0] m0_dout,
  input  logic        m1_wr,
  input  logic [7:0]  m1_addr,
  input  logic [31:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic        s_wr,
  output logic [7:0]  s_addr,
  output logic [31:0] s_din
);

  localparam int CW = $clog2(MAX_HOLD);

  localparam logic [0:0] M0_GRANT = 1'b0;
  localparam logic [0:0] M1_GRANT = 1'b1;

  // Value of the hold counter on the owner's last contended cycle.
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_hold_cnt;

  logic [0:0]    w_state_next;
  logic [CW-1:0] w_hold_next;
  logic          w_contend;
  logic          w_hold_done;

  assign w_contend   = m0_req & m1_req;
  assign w_hold_done = (r_hold_cnt == HOLD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = '0;
    if (w_contend) begin
      // Owner keeps the bus until its quota of contended cycles is used up;
      // the counter restarts from zero for the new owner.
      if (w_hold_done) begin
        w_state_next = (r_state == M0_GRANT) ? M1_GRANT : M0_GRANT;
        w_hold_next  = '0;
      end else begin
        w_hold_next  = r_hold_cnt + 1'b1;
      end
    end else begin
      // Without contention the sole requester owns the bus; an idle bus
      // parks on master 0.
      if (m1_req) begin
        w_state_next = M1_GRANT;
      end else begin
        w_state_next = M0_GRANT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= M0_GRANT;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
    end
  end

  assign m0_grant = (r_state == M0_GRANT);
  assign m1_grant = (r_state == M1_GRANT);

  // Slave-side signals follow the granted master with no added latency.
  assign s_wr   = m1_grant ? m1_wr   : m0_wr;
  assign s_addr = m1_grant ? m1_addr : m0_addr;
  assign s_din  = m1_grant ? m1_dout : m0_dout;

endmodule
